siphash_nonce_ctrl: RTL
=======================

SIPHASH_NONCE_CTRL -- requirements
Module: siphash_nonce_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 10: cycles from hash_we high to the matching hash_result.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: hit FIFO entries, power of two, at least 2.
REQ-003 CLOCK  input  1  clock, rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin a nonce sweep; sampled only in IDLE.
REQ-006 stop  input  1  abort issuing; sampled only in RUN.
REQ-007 base_nonce  input  64  first nonce of the sweep.
REQ-008 count  input  32  number of nonces to issue.
REQ-009 mask  input  64  hit when (hash_result & mask) == 0.
REQ-010 hash_we  output  1  nonce-issue strobe to the hash core.
REQ-011 hash_nonce  output  64  nonce to the hash core.
REQ-012 hash_result  input  64  hash core output.
REQ-013 hit_valid  output  1  FIFO head valid.
REQ-014 hit_ready  input  1  consumer accepts the head.
REQ-015 hit_nonce  output  64  nonce of the head hit.
REQ-016 hit_result  output  64  hash of the head hit.
REQ-017 busy  output  1  high in RUN or DRAIN.
REQ-018 finished  output  1  one-cycle pulse at sweep end.
REQ-019 overflow  output  1  sticky: a hit was dropped.

Function
REQ-020 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start with count!=0; IDLE->DRAIN on start with count==0.
- RUN->DRAIN on the last issue or on stop.
- DRAIN->DONE when no tag is in flight.
- DONE->IDLE after one cycle.
REQ-021 On accepted start SHALL load nonce=base_nonce and remaining=count, latch mask, and clear overflow.
REQ-022 In RUN SHALL drive hash_we=1 with hash_nonce=current nonce each cycle, then increment the nonce modulo 2^64 (FFFF_FFFF_FFFF_FFFF wraps to 0) and decrement remaining.
- Every cycle is issued; back-to-back issue, no gaps.
REQ-023 stop in RUN SHALL suppress issue in that same cycle.
REQ-024 SHALL carry a LATENCY-deep tag shift register of {valid, nonce}, advancing every cycle.
- The tag leaving the register aligns with hash_result.
REQ-025 When the emerging tag is valid and (hash_result & latched mask)==0, SHALL push {nonce, hash_result} into the FIFO.
- hit_valid rises LATENCY+1 cycles after the issue.
REQ-026 hit handshake:
- Pop on hit_valid && hit_ready.
- hit_nonce/hit_result SHALL hold stable while hit_valid && !hit_ready.
REQ-027 FIFO full on push without a same-cycle pop SHALL drop the hit and set overflow.
- Simultaneous push and pop at full SHALL both succeed.
REQ-028 Push and pop at empty SHALL store the entry; hit_valid rises the next cycle (no bypass).
REQ-029 finished SHALL pulse in DONE only.
- busy SHALL be 0 in IDLE and DONE.
REQ-030 start in any state other than IDLE SHALL be ignored.
- The FIFO keeps draining in every state.

Reset
REQ-031 reset_n low SHALL force IDLE and clear the FIFO, the tag register, nonce and remaining.
- Outputs SHALL reset to: hash_we=0, hash_nonce=0, hit_valid=0, hit_nonce=0, hit_result=0, busy=0, finished=0, overflow=0.
REQ-032 Reset mid-sweep SHALL discard in-flight tags.
- No hit SHALL be reported for hashes issued before reset.

Configuration
REQ-033 With SIPHASH_NONCE_STATS_EN defined SHALL add outputs:
- hash_count, 32 bits: issued hashes this sweep, saturating.
- hit_count, 32 bits: pushed hits this sweep, saturating.
- Both SHALL clear on accepted start and on reset.
REQ-034 Without SIPHASH_NONCE_STATS_EN those ports and counters SHALL not exist.

Structure
REQ-035 The shared package siphash_pkg SHALL hold:
- typedef nonce_t (64 bits).
- typedef hit_t {nonce_t nonce; logic [63:0] result}.
- The FSM state enum.
- Constant SIPHASH_LATENCY = 10.
REQ-036 The FIFO SHALL be sub-module siphash_hit_fifo (parameter DEPTH, element hit_t, valid/ready pop, full/overflow).

Verification
REQ-037 base=0, count=5, mask=0 -> hash_we high 5 cycles, nonces 0..4; 5 hits in order; finished pulses once.
REQ-038 base=FFFF_FFFF_FFFF_FFFE, count=3 -> nonces ...FE, ...FF, 0.
REQ-039 mask=0, count=8, hit_ready=0, FIFO_DEPTH=4 -> 4 hits held, overflow=1; pop all yields nonces 0..3.
REQ-040 count=100, stop at the 10th issue -> exactly 10 nonces issued; finished LATENCY+1 cycles later.
REQ-041 count=0 -> no hash_we, finished pulse within LATENCY+2 cycles.
REQ-042 reset at the 3rd issue -> all outputs at reset values; no hit_valid for the next 2*LATENCY cycles.

Source files
------------

// File: rtl/siphash_pkg.sv
// Shared types and constants for the SipHash nonce sweep controller.
package siphash_pkg;

    typedef logic [63:0] nonce_t;

    typedef struct packed {
        nonce_t      nonce;
        logic [63:0] result;
    } hit_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int unsigned SIPHASH_LATENCY = 10;

endpackage

// File: rtl/siphash_hit_fifo.sv
// Hit FIFO: power-of-two depth, valid/ready pop, no write-to-read bypass.
module siphash_hit_fifo
    import siphash_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic CLOCK,
    input  logic reset_n,
    input  logic i_push_valid,
    input  hit_t i_push_data,
    output logic o_full,
    output logic o_pop_valid,
    input  logic i_pop_ready,
    output hit_t o_pop_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    hit_t        r_mem [DEPTH];

    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && i_pop_ready;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_push  = i_push_valid && (!o_full || w_pop);

    assign o_pop_valid = !w_empty;
    assign o_pop_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge CLOCK) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/siphash_nonce_ctrl.sv
// Nonce sweep controller: issues nonces to a fixed-latency hash core and queues masked hits.
// Optional SIPHASH_NONCE_STATS_EN adds per-sweep hash_count/hit_count outputs.
module siphash_nonce_ctrl
    import siphash_pkg::*;
#(
    parameter int unsigned LATENCY    = SIPHASH_LATENCY,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLOCK,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [63:0] base_nonce,
    input  logic [31:0] count,
    input  logic [63:0] mask,
    output logic        hash_we,
    output logic [63:0] hash_nonce,
    input  logic [63:0] hash_result,
    output logic        hit_valid,
    input  logic        hit_ready,
    output logic [63:0] hit_nonce,
    output logic [63:0] hit_result,
    output logic        busy,
    output logic        finished,
`ifdef SIPHASH_NONCE_STATS_EN
    output logic [31:0] hash_count,
    output logic [31:0] hit_count,
`endif
    output logic        overflow
);

    state_t             r_state;
    nonce_t             r_nonce;
    logic [31:0]        r_remaining;
    logic [63:0]        r_mask;
    logic               r_overflow;
    logic [LATENCY-1:0] r_tag_v;
    nonce_t             r_tag_n [LATENCY];

    logic w_issue;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_fifo_full;
    hit_t w_push_data;
    hit_t w_pop_data;

    assign w_issue = (r_state == S_RUN) && !stop;
    assign w_push  = r_tag_v[LATENCY-1] && ((hash_result & r_mask) == '0);
    assign w_pop   = hit_valid && hit_ready;
    assign w_drop  = w_push && w_fifo_full && !w_pop;

    assign w_push_data.nonce  = r_tag_n[LATENCY-1];
    assign w_push_data.result = hash_result;

    assign hash_we    = w_issue;
    assign hash_nonce = r_nonce;
    assign hit_nonce  = w_pop_data.nonce;
    assign hit_result = w_pop_data.result;
    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign finished   = (r_state == S_DONE);
    assign overflow   = r_overflow;

    // Tag line mirrors the hash core pipeline so the emerging tag meets its result.
    always_ff @(posedge CLOCK) begin
        if (!reset_n) begin
            r_tag_v <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) r_tag_n[i] <= '0;
        end else begin
            r_tag_v[0] <= w_issue;
            r_tag_n[0] <= r_nonce;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_n[i] <= r_tag_n[i-1];
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_nonce     <= '0;
            r_remaining <= '0;
            r_mask      <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_nonce     <= base_nonce;
                        r_remaining <= count;
                        r_mask      <= mask;
                        r_overflow  <= 1'b0;
                        r_state     <= (count != '0) ? S_RUN : S_DRAIN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_nonce     <= r_nonce + 64'd1;
                        r_remaining <= r_remaining - 32'd1;
                        if (r_remaining == 32'd1) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_tag_v == '0) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SIPHASH_NONCE_STATS_EN
    logic [31:0] r_hash_count;
    logic [31:0] r_hit_count;

    always_ff @(posedge CLOCK) begin
        if (!reset_n) begin
            r_hash_count <= '0;
            r_hit_count  <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_hash_count <= '0;
            r_hit_count  <= '0;
        end else begin
            if (w_issue && r_hash_count != '1) r_hash_count <= r_hash_count + 32'd1;
            if (w_push && !w_drop && r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
        end
    end

    assign hash_count = r_hash_count;
    assign hit_count  = r_hit_count;
`endif

    siphash_hit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_hit_fifo (
        .CLOCK        (CLOCK),
        .reset_n      (reset_n),
        .i_push_valid (w_push),
        .i_push_data  (w_push_data),
        .o_full       (w_fifo_full),
        .o_pop_valid  (hit_valid),
        .i_pop_ready  (hit_ready),
        .o_pop_data   (w_pop_data)
    );

endmodule
